// File: rtl/core_pkg.sv
// Shared types for the register-file write-back path: widths, the write request
// record and the source-select encoding used by the write-back arbiter.
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_EX,
    SRC_LD,
    SRC_MD
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests. Push is ignored when full and pop when empty,
// so callers may drive both freely; DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wb_req_t         mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset: the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_req;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: merges EX, LD and buffered MD results into one registered
// write per cycle and tracks outstanding long-op destinations for decode hazard checks.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int unsigned MD_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [XLEN-1:0]      ex_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  input  logic                 md_valid,
  output logic                 md_ready,
  input  logic [REG_IDX_W-1:0] md_rd,
  input  logic [XLEN-1:0]      md_data,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] rd_index,
  output logic [XLEN-1:0]      wb_data,
  output logic [31:0]          busy
);

  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);

  wb_req_t              fifo_head;
  wb_req_t              md_req;
  logic                 fifo_full, fifo_empty;
  logic                 fifo_push, fifo_pop;
  logic                 ld_block;

  wb_src_e              sel;
  wb_req_t              sel_req;

  logic [StW-1:0]       starve_q, starve_d;
  logic [31:0]          busy_q, busy_d;
  logic                 wb_en_q, wb_en_d;
  logic [REG_IDX_W-1:0] rd_index_q, rd_index_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;

  assign md_req    = '{rd: md_rd, data: md_data};
  assign md_ready  = !fifo_full;
  assign fifo_push = md_valid && md_ready;
  assign fifo_pop  = (sel == SRC_MD);

  wb_fifo #(
    .DEPTH(MD_DEPTH)
  ) u_md_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .push_req(md_req),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // LD yields once the MD head has waited long enough, so MD cannot be starved forever.
  assign ld_block = (starve_q >= StW'(STARVE_LIMIT)) && !fifo_empty;
  assign ld_ready = !ex_valid && !ld_block;

  always_comb begin
    sel     = SRC_NONE;
    sel_req = '0;
    if (ex_valid) begin
      sel     = SRC_EX;
      sel_req = '{rd: ex_rd, data: ex_data};
    end else if (ld_valid && !ld_block) begin
      sel     = SRC_LD;
      sel_req = '{rd: ld_rd, data: ld_data};
    end else if (!fifo_empty) begin
      sel     = SRC_MD;
      sel_req = fifo_head;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q < StW'(STARVE_LIMIT)) begin
      starve_d = starve_q + StW'(1);
    end
  end

  // Clear before set so an issue to the same register in the write cycle stays pending.
  always_comb begin
    busy_d = busy_q;
    if (sel == SRC_LD || sel == SRC_MD) begin
      busy_d[sel_req.rd] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // x0 results consume their slot and load the data path but never raise the write enable.
  always_comb begin
    wb_en_d    = 1'b0;
    rd_index_d = rd_index_q;
    wb_data_d  = wb_data_q;
    if (sel != SRC_NONE) begin
      wb_en_d    = (sel_req.rd != '0);
      rd_index_d = sel_req.rd;
      wb_data_d  = sel_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      busy_q     <= '0;
      wb_en_q    <= 1'b0;
      rd_index_q <= '0;
      wb_data_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      wb_en_q    <= wb_en_d;
      rd_index_q <= rd_index_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign wb_en    = wb_en_q;
  assign rd_index = rd_index_q;
  assign wb_data  = wb_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, all checked against a
// queue-based reference model and a scoreboard of expected register-file writes.
module tb_wb_arbiter;

  localparam int unsigned MD_DEPTH     = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        ex_valid, ld_valid, md_valid, iss_valid;
  logic [4:0]  ex_rd, ld_rd, md_rd, iss_rd;
  logic [31:0] ex_data, ld_data, md_data;
  logic        ld_ready, md_ready;
  logic        wb_en;
  logic [4:0]  rd_index;
  logic [31:0] wb_data;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t        mq[$];
  ent_t        wq[$];
  int          head_age = 0;
  logic [31:0] m_busy   = '0;
  logic        exp_wen  = 1'b0;
  logic [4:0]  last_rd  = '0;
  logic [31:0] last_data = '0;

  wb_arbiter #(
    .MD_DEPTH    (MD_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_rd    (ex_rd),
    .ex_data  (ex_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_rd    (ld_rd),
    .ld_data  (ld_data),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_rd    (md_rd),
    .md_data  (md_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .wb_en    (wb_en),
    .rd_index (rd_index),
    .wb_data  (wb_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluated mid-cycle with inputs stable, predicts this cycle's handshakes and the
  // state the DUT must show after the coming posedge.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      head_age  = 0;
      m_busy    = '0;
      exp_wen   = 1'b0;
      last_rd   = '0;
      last_data = '0;
    end else begin
      bit   exp_ldr, exp_mdr, picked, popped, was_empty;
      ent_t s;
      was_empty = (mq.size() == 0);
      exp_ldr   = !ex_valid && !(head_age >= STARVE_LIMIT && !was_empty);
      exp_mdr   = (mq.size() < MD_DEPTH);
      check("ld_ready", ld_ready, exp_ldr);
      check("md_ready", md_ready, exp_mdr);
      picked = 0;
      popped = 0;
      if (ex_valid) begin
        s.rd = ex_rd; s.data = ex_data; picked = 1;
      end else if (ld_valid && exp_ldr) begin
        s.rd = ld_rd; s.data = ld_data; picked = 1;
        m_busy[ld_rd] = 1'b0;
      end else if (!was_empty) begin
        s = mq.pop_front(); picked = 1; popped = 1;
        m_busy[s.rd] = 1'b0;
      end
      head_age = (popped || was_empty) ? 0 : head_age + 1;
      if (md_valid && exp_mdr) begin
        ent_t e;
        e.rd = md_rd; e.data = md_data;
        mq.push_back(e);
      end
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
      exp_wen = picked && (s.rd != 0);
      if (picked) begin
        last_rd   = s.rd;
        last_data = s.data;
      end
      if (exp_wen) wq.push_back(s);
    end
  end

  // Monitor: consumes expected writes whenever the DUT presents one.
  always @(posedge clk) begin
    #2;
    check("wb_en", wb_en, exp_wen);
    if (wb_en === 1'b1) begin
      if (wq.size() == 0) begin
        check("wb_unexpected", 1, 0);
      end else begin
        ent_t e;
        e = wq.pop_front();
        check("wb_rd", rd_index, e.rd);
        check("wb_data", wb_data, e.data);
      end
    end else if (exp_wen && wq.size() > 0) begin
      void'(wq.pop_front());
    end
    check("rd_index_hold", rd_index, last_rd);
    check("wb_data_hold", wb_data, last_data);
    check("busy", busy, m_busy);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ld_valid = 0; md_valid = 0; iss_valid = 0;
  endtask

  initial begin
    rst = 1; idle();
    ex_rd = 0; ld_rd = 0; md_rd = 0; iss_rd = 0;
    ex_data = 0; ld_data = 0; md_data = 0;
    step(); step();
    check("rst_wb_en", wb_en, 0);
    check("rst_rd_index", rd_index, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_md_ready", md_ready, 1);
    rst = 0;
    step();

    // EX beats LD
    ex_valid = 1; ex_rd = 5; ex_data = 32'hDEADBEEF;
    ld_valid = 1; ld_rd = 9; ld_data = 32'h1;
    #1 check("ex_blocks_ld", ld_ready, 0);
    step(); idle();
    check("ex_wb_en", wb_en, 1);
    check("ex_rd_index", rd_index, 5);
    check("ex_wb_data", wb_data, 32'hDEADBEEF);

    // Scoreboard set and clear by LD
    iss_valid = 1; iss_rd = 7;
    step(); idle();
    check("busy7_set", busy[7], 1);
    step();
    ld_valid = 1; ld_rd = 7; ld_data = 32'h11;
    #1 check("busy7_before", busy[7], 1);
    step(); idle();
    check("ld_wb_en", wb_en, 1);
    check("ld_rd_index", rd_index, 7);
    check("busy7_clear", busy[7], 0);

    // MD FIFO fills while EX holds the port, then drains in order
    ex_valid = 1; ex_rd = 1; ex_data = 32'hA;
    md_valid = 1; md_rd = 10; md_data = 32'h100;
    step();
    md_rd = 11; md_data = 32'h101;
    step();
    md_rd = 12; md_data = 32'h102;
    #1 check("md_full", md_ready, 0);
    step(); idle();
    step();
    check("md_drain0_rd", rd_index, 10);
    check("md_drain0_data", wb_data, 32'h100);
    step();
    check("md_drain1_rd", rd_index, 11);
    check("md_drain1_data", wb_data, 32'h101);
    step();
    check("md_drained", wb_en, 0);

    // LD starvation of a queued MD result
    md_valid = 1; md_rd = 13; md_data = 32'h200;
    ld_valid = 1; ld_rd = 20; ld_data = 32'h300;
    step();
    md_valid = 0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      #1 check("ld_ready_pre_block", ld_ready, 1);
      step();
    end
    check("ld_blocked", ld_ready, 0);
    step();
    check("starve_md_rd", rd_index, 13);
    check("starve_md_data", wb_data, 32'h200);
    check("starve_released", ld_ready, 1);
    idle();

    // x0 destinations
    ex_valid = 1; ex_rd = 0; ex_data = 32'h55;
    iss_valid = 1; iss_rd = 0;
    step(); idle();
    check("x0_wb_en", wb_en, 0);
    check("x0_rd_index", rd_index, 0);
    check("x0_wb_data", wb_data, 32'h55);
    check("x0_busy", busy, 0);

    // Reset with a full FIFO and a pending destination
    ex_valid = 1; ex_rd = 2; ex_data = 32'h7;
    md_valid = 1; md_rd = 14; md_data = 32'h400;
    iss_valid = 1; iss_rd = 3;
    step();
    iss_valid = 0; md_rd = 15; md_data = 32'h401;
    step();
    md_valid = 0;
    check("pre_rst_busy3", busy[3], 1);
    check("pre_rst_full", md_ready, 0);
    rst = 1; ex_valid = 0;
    step();
    rst = 0;
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_md_ready", md_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_write", wb_en, 0);
    end

    // Randomized traffic with varying EX pressure
    for (int ph = 0; ph < 12; ph++) begin
      int ex_pct;
      ex_pct = $urandom_range(0, 90);
      for (int c = 0; c < 200; c++) begin
        rst       = ($urandom_range(0, 299) == 0);
        ex_valid  = ($urandom_range(0, 99) < ex_pct);
        ex_rd     = 5'($urandom_range(0, 9));
        ex_data   = $urandom;
        ld_valid  = ($urandom_range(0, 1) == 0);
        ld_rd     = 5'($urandom_range(0, 9));
        ld_data   = $urandom;
        md_valid  = ($urandom_range(0, 9) < 4);
        md_rd     = 5'($urandom_range(0, 9));
        md_data   = $urandom;
        iss_valid = ($urandom_range(0, 9) < 3);
        iss_rd    = 5'($urandom_range(0, 9));
        step();
      end
    end
    rst = 0; idle();
    for (int i = 0; i < 6; i++) step();
    check("scoreboard_empty", wq.size(), 0);
    check("model_fifo_empty", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
